// File: rtl/mat_loader.sv
// mat_loader: streams matrix A then matrix B into the engine's memories,
// packing N words per row, then kicks the engine and reports completion.
// Element 0 of each row sits in the least-significant word of the packed row.
module mat_loader #(
  parameter int DATA_LEN      = 32,
  parameter int N             = 8,
  parameter int M             = 8,
  parameter int ADDRESS_SIZE  = 4,
  parameter int A_ADDR_OFFSET = 8,
  parameter int B_ADDR_OFFSET = 0
) (
  input  logic                    i_clk,
  input  logic                    i_rstn,
  input  logic                    i_load,
  input  logic [DATA_LEN-1:0]     i_data,
  input  logic                    i_valid,
  output logic                    o_ready,
  output logic [ADDRESS_SIZE-1:0] o_address_A,
  output logic [DATA_LEN*N-1:0]   o_write_data_A,
  output logic                    o_wr_en_A,
  output logic [ADDRESS_SIZE-1:0] o_address_B,
  output logic [DATA_LEN*N-1:0]   o_write_data_B,
  output logic                    o_wr_en_B,
  output logic                    o_mem_sel,
  output logic                    o_mat_start,
  input  logic                    i_mat_done,
  output logic [2:0]              o_state,
  output logic                    o_done
);

  localparam int ROW_W = DATA_LEN * N;
  localparam int WCW   = (N > 1) ? $clog2(N) : 1;
  localparam int RCW   = (M > 1) ? $clog2(M) : 1;

  localparam logic [2:0] S_IDLE   = 3'd7;
  localparam logic [2:0] S_LOAD_A = 3'd0;
  localparam logic [2:0] S_LOAD_B = 3'd1;
  localparam logic [2:0] S_FLUSH  = 3'd2;
  localparam logic [2:0] S_START  = 3'd3;
  localparam logic [2:0] S_WAIT   = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  // Insert one word into its slot of a partially packed row.
  function automatic logic [ROW_W-1:0] merge_word(
    input logic [ROW_W-1:0]    row,
    input logic [WCW-1:0]      idx,
    input logic [DATA_LEN-1:0] word
  );
    logic [ROW_W-1:0] r;
    r = row;
    r[DATA_LEN*idx +: DATA_LEN] = word;
    return r;
  endfunction

  // Memory address of a given row relative to the matrix base address.
  function automatic logic [ADDRESS_SIZE-1:0] row_addr(
    input int             base,
    input logic [RCW-1:0] row
  );
    return ADDRESS_SIZE'(base) + ADDRESS_SIZE'(row);
  endfunction

  logic [2:0]              state_p0;
  logic [2:0]              state_nxt;
  logic [WCW-1:0]          word_cnt_p0;
  logic [RCW-1:0]          row_cnt_p0;
  logic [ROW_W-1:0]        pack_p0;
  logic [ROW_W-1:0]        row_full;
  logic                    acc_p0;
  logic                    last_word;
  logic                    last_row;
  logic                    row_done_a;
  logic                    row_done_b;
  logic [ROW_W-1:0]        row_a_p1;
  logic [ROW_W-1:0]        row_b_p1;
  logic [ADDRESS_SIZE-1:0] addr_a_p1;
  logic [ADDRESS_SIZE-1:0] addr_b_p1;
  logic                    vld_a_p1;
  logic                    vld_b_p1;

  // Stage p0: handshake, counter decode and row assembly.
  assign o_ready    = (state_p0 == S_LOAD_A) || (state_p0 == S_LOAD_B);
  assign acc_p0     = i_valid & o_ready;
  assign last_word  = (word_cnt_p0 == WCW'(N - 1));
  assign last_row   = (row_cnt_p0 == RCW'(M - 1));
  assign row_full   = merge_word(pack_p0, word_cnt_p0, i_data);
  assign row_done_a = acc_p0 && last_word && (state_p0 == S_LOAD_A);
  assign row_done_b = acc_p0 && last_word && (state_p0 == S_LOAD_B);

  // Next-state decode; unknown encodings fall back to IDLE.
  always_comb begin
    state_nxt = S_IDLE;
    case (state_p0)
      S_IDLE:   state_nxt = i_load ? S_LOAD_A : S_IDLE;
      S_LOAD_A: state_nxt = (row_done_a && last_row) ? S_LOAD_B : S_LOAD_A;
      S_LOAD_B: state_nxt = (row_done_b && last_row) ? S_FLUSH : S_LOAD_B;
      S_FLUSH:  state_nxt = S_START;
      S_START:  state_nxt = S_WAIT;
      S_WAIT:   state_nxt = i_mat_done ? S_DONE : S_WAIT;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) state_p0 <= S_IDLE;
    else         state_p0 <= state_nxt;
  end

  // Word and row counters advance only on accepted words and wrap per row/matrix.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      word_cnt_p0 <= '0;
      row_cnt_p0  <= '0;
    end else if (acc_p0) begin
      if (last_word) begin
        word_cnt_p0 <= '0;
        row_cnt_p0  <= last_row ? '0 : row_cnt_p0 + RCW'(1);
      end else begin
        word_cnt_p0 <= word_cnt_p0 + WCW'(1);
      end
    end
  end

  // Pack register collects words of the row in progress; cleared once the row is handed off.
  always_ff @(posedge i_clk) begin
    if (!i_rstn)     pack_p0 <= '0;
    else if (acc_p0) pack_p0 <= last_word ? '0 : row_full;
  end

  // Stage p1: completed row, its address and a one-cycle write strobe per memory.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      row_a_p1  <= '0;
      row_b_p1  <= '0;
      addr_a_p1 <= '0;
      addr_b_p1 <= '0;
      vld_a_p1  <= 1'b0;
      vld_b_p1  <= 1'b0;
    end else begin
      vld_a_p1 <= row_done_a;
      vld_b_p1 <= row_done_b;
      if (row_done_a) begin
        row_a_p1  <= row_full;
        addr_a_p1 <= row_addr(A_ADDR_OFFSET, row_cnt_p0);
      end
      if (row_done_b) begin
        row_b_p1  <= row_full;
        addr_b_p1 <= row_addr(B_ADDR_OFFSET, row_cnt_p0);
      end
    end
  end

  assign o_address_A    = addr_a_p1;
  assign o_write_data_A = row_a_p1;
  assign o_wr_en_A      = vld_a_p1;
  assign o_address_B    = addr_b_p1;
  assign o_write_data_B = row_b_p1;
  assign o_wr_en_B      = vld_b_p1;
  assign o_mem_sel      = (state_p0 == S_LOAD_A) || (state_p0 == S_LOAD_B) ||
                          (state_p0 == S_FLUSH);
  assign o_mat_start    = (state_p0 == S_START);
  assign o_done         = (state_p0 == S_DONE);
  assign o_state        = state_p0;

endmodule
